// File: rtl/pid_pkg.sv
// Shared types and helpers for the PID position controller: operating modes,
// FSM state encoding and a wide signed saturation function used at every
// point where a value is narrowed.
package pid_pkg;

  // Width of the internal "safe" arithmetic domain. Every narrowing point
  // first forms its value in this width, then saturates into the target width.
  // It must hold a 2W-bit product, which limits W to 32.
  localparam int SW = 64;

  typedef enum logic [1:0] {
    MODE_P   = 2'd0,
    MODE_PD  = 2'd1,
    MODE_PI  = 2'd2,
    MODE_PID = 2'd3
  } pid_mode_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ERR   = 3'd1,
    S_MUL_P = 3'd2,
    S_MUL_I = 3'd3,
    S_MUL_D = 3'd4,
    S_SUM   = 3'd5,
    S_DONE  = 3'd6
  } pid_state_e;

  // Clamp a signed value into [lo, hi].
  function automatic logic signed [SW-1:0] sat_signed(
    input logic signed [SW-1:0] value,
    input logic signed [SW-1:0] hi,
    input logic signed [SW-1:0] lo
  );
    if (value > hi) begin
      return hi;
    end else if (value < lo) begin
      return lo;
    end else begin
      return value;
    end
  endfunction

  // Modes that use the integral term.
  function automatic logic mode_has_i(input pid_mode_e m);
    return (m == MODE_PI) || (m == MODE_PID);
  endfunction

  // Modes that use the derivative term.
  function automatic logic mode_has_d(input pid_mode_e m);
    return (m == MODE_PD) || (m == MODE_PID);
  endfunction

endpackage

// File: rtl/pid_mul_shift.sv
// Shared signed W x W multiplier with an arithmetic right shift by FRAC.
// The 2W-bit product is shifted (floor toward minus infinity) and then
// saturated back into W bits, so a large gain times a large operand pins at
// the W-bit rail instead of wrapping.
module pid_mul_shift
  import pid_pkg::*;
#(
  parameter int W    = 16,
  parameter int FRAC = 8
) (
  input  logic signed [W-1:0] a_i,
  input  logic signed [W-1:0] b_i,
  output logic signed [W-1:0] y_o
);

  localparam logic signed [SW-1:0] Y_HI = (64'sd1 <<< (W - 1)) - 64'sd1;
  localparam logic signed [SW-1:0] Y_LO = -(64'sd1 <<< (W - 1));

  logic signed [2*W-1:0] prod;
  logic signed [2*W-1:0] shr;
  logic signed [SW-1:0]  shr_w;

  assign prod  = a_i * b_i;
  assign shr   = prod >>> FRAC;
  assign shr_w = SW'(shr);
  assign y_o   = W'(sat_signed(shr_w, Y_HI, Y_LO));

endmodule

// File: rtl/pid_position_ctrl.sv
// Fixed-point PID position controller. A sample (sensor, target, gains, mode)
// is accepted in IDLE, then one shared multiplier is stepped through the P, I
// and D products by a seven-state FSM. The result is clamped to
// [OUT_MIN, OUT_MAX] and announced with a one-cycle out_valid pulse six cycles
// after the accept edge.
//
// Handshake: sample_ready is high exactly when the FSM is in IDLE; a sample is
// taken on the rising edge where sample_valid && sample_ready. Anything offered
// while busy is ignored, and the producer must keep sample_valid high until it
// sees the accept edge.
module pid_position_ctrl
  import pid_pkg::*;
#(
  parameter int W       = 16,
  parameter int FRAC    = 8,
  parameter int OUT_MAX = 1000,
  parameter int OUT_MIN = -1000,
  parameter int I_MAX   = 4096
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sample_valid,
  output logic         sample_ready,
  input  logic [W-1:0] sensor,
  input  logic [W-1:0] target,
  input  logic [W-1:0] kp,
  input  logic [W-1:0] ki,
  input  logic [W-1:0] kd,
  input  logic [1:0]   mode,
  input  logic         clear_i,
  output logic [W-1:0] pwm_out,
  output logic         out_valid,
  output logic         sat_flag,
  output logic [2:0]   state_o
);

  localparam logic signed [SW-1:0] W_HI = (64'sd1 <<< (W - 1)) - 64'sd1;
  localparam logic signed [SW-1:0] W_LO = -(64'sd1 <<< (W - 1));
  localparam logic signed [SW-1:0] O_HI = SW'(OUT_MAX);
  localparam logic signed [SW-1:0] O_LO = SW'(OUT_MIN);
  localparam logic signed [SW-1:0] I_HI = SW'(I_MAX);
  localparam logic signed [SW-1:0] I_LO = -SW'(I_MAX);

  pid_state_e state_q, state_d;

  // Latched sample
  logic signed [W-1:0] sensor_q, sensor_d;
  logic signed [W-1:0] target_q, target_d;
  logic signed [W-1:0] kp_q, kp_d;
  logic signed [W-1:0] ki_q, ki_d;
  logic signed [W-1:0] kd_q, kd_d;
  pid_mode_e           mode_q, mode_d;

  // Per-sample intermediates
  logic signed [W-1:0] e_q, e_d;
  logic signed [W-1:0] d_q, d_d;
  logic signed [W-1:0] p_q, p_d;
  logic signed [W-1:0] i_q, i_d;
  logic signed [W-1:0] dterm_q, dterm_d;

  // History carried between samples
  logic signed [W-1:0] i_acc_q, i_acc_d;
  logic signed [W-1:0] e_last_q, e_last_d;
  logic                first_q, first_d;
  logic                sat_hi_q, sat_hi_d;
  logic                sat_lo_q, sat_lo_d;
  logic                clr_pend_q, clr_pend_d;

  // Outputs
  logic signed [W-1:0] pwm_q, pwm_d;
  logic                sat_flag_q, sat_flag_d;
  logic                out_valid_q, out_valid_d;

  // Combinational datapath
  logic                accept;
  logic                clr_now;
  logic                has_i, has_d;
  logic                e_pos, e_neg, windup;
  logic signed [SW-1:0] e_wide, d_wide, i_cand, u_wide;
  logic signed [W-1:0]  e_now, d_now, i_acc_new;
  logic                 u_hi, u_lo;
  logic signed [W-1:0]  mul_a, mul_b, mul_y;

  assign accept = sample_valid && (state_q == S_IDLE);

  // A clear in IDLE takes effect on the next edge (ahead of a simultaneous
  // accept); a clear seen while busy waits for the DONE->IDLE edge so the
  // in-flight result is computed from the old history.
  assign clr_now = (clear_i && (state_q == S_IDLE)) ||
                   ((state_q == S_DONE) && (clr_pend_q || clear_i));

  assign has_i = mode_has_i(mode_q);
  assign has_d = mode_has_d(mode_q);

  // Error and derivative, both formed wide and saturated to W.
  assign e_wide = SW'(target_q) - SW'(sensor_q);
  assign e_now  = W'(sat_signed(e_wide, W_HI, W_LO));
  assign d_wide = SW'(e_now) - SW'(e_last_q);
  assign d_now  = first_q ? '0 : W'(sat_signed(d_wide, W_HI, W_LO));

  // Integrator candidate with clamp and conditional-integration anti-windup:
  // do not push further into a rail the previous output already hit.
  assign e_pos     = !e_q[W-1] && (e_q != '0);
  assign e_neg     = e_q[W-1];
  assign windup    = (sat_hi_q && e_pos) || (sat_lo_q && e_neg);
  assign i_cand    = SW'(i_acc_q) + SW'(e_q);
  assign i_acc_new = windup ? i_acc_q : W'(sat_signed(i_cand, I_HI, I_LO));

  // Sum of terms; three W-bit terms cannot overflow the wide domain.
  assign u_wide = SW'(p_q) + SW'(i_q) + SW'(dterm_q);
  assign u_hi   = u_wide > O_HI;
  assign u_lo   = u_wide < O_LO;

  // Route operands of the shared multiplier by FSM state.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_q)
      S_MUL_P: begin
        mul_a = kp_q;
        mul_b = e_q;
      end
      S_MUL_I: begin
        mul_a = ki_q;
        mul_b = i_acc_new;
      end
      S_MUL_D: begin
        mul_a = kd_q;
        mul_b = d_q;
      end
      default: begin
        mul_a = '0;
        mul_b = '0;
      end
    endcase
  end

  pid_mul_shift #(
    .W    (W),
    .FRAC (FRAC)
  ) u_mul (
    .a_i (mul_a),
    .b_i (mul_b),
    .y_o (mul_y)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: fixed walk through the stages, no stalls.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_ERR;
      S_ERR:   state_d = S_MUL_P;
      S_MUL_P: state_d = S_MUL_I;
      S_MUL_I: state_d = S_MUL_D;
      S_MUL_D: state_d = S_SUM;
      S_SUM:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next state: each stage writes only its own registers.
  always_comb begin
    sensor_d    = sensor_q;
    target_d    = target_q;
    kp_d        = kp_q;
    ki_d        = ki_q;
    kd_d        = kd_q;
    mode_d      = mode_q;
    e_d         = e_q;
    d_d         = d_q;
    p_d         = p_q;
    i_d         = i_q;
    dterm_d     = dterm_q;
    i_acc_d     = i_acc_q;
    e_last_d    = e_last_q;
    first_d     = first_q;
    sat_hi_d    = sat_hi_q;
    sat_lo_d    = sat_lo_q;
    pwm_d       = pwm_q;
    sat_flag_d  = sat_flag_q;
    out_valid_d = (state_q == S_DONE);
    clr_pend_d  = clr_pend_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          sensor_d = sensor;
          target_d = target;
          kp_d     = kp;
          ki_d     = ki;
          kd_d     = kd;
          mode_d   = pid_mode_e'(mode);
        end
      end
      S_ERR: begin
        e_d = e_now;
        d_d = d_now;
      end
      S_MUL_P: begin
        p_d = mul_y;
      end
      S_MUL_I: begin
        if (has_i) begin
          i_acc_d = i_acc_new;
          i_d     = mul_y;
        end else begin
          i_d = '0;
        end
      end
      S_MUL_D: begin
        dterm_d = has_d ? mul_y : '0;
      end
      S_SUM: begin
        pwm_d      = W'(sat_signed(u_wide, O_HI, O_LO));
        sat_flag_d = u_hi || u_lo;
        sat_hi_d   = u_hi;
        sat_lo_d   = u_lo;
        e_last_d   = e_q;
        first_d    = 1'b0;
      end
      default: begin
      end
    endcase

    if (clr_now) begin
      i_acc_d  = '0;
      e_last_d = '0;
      first_d  = 1'b1;
      sat_hi_d = 1'b0;
      sat_lo_d = 1'b0;
    end

    if ((state_q == S_IDLE) || (state_q == S_DONE)) begin
      clr_pend_d = 1'b0;
    end else if (clear_i) begin
      clr_pend_d = 1'b1;
    end
  end

  // Datapath registers; reset aborts any sample in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sensor_q    <= '0;
      target_q    <= '0;
      kp_q        <= '0;
      ki_q        <= '0;
      kd_q        <= '0;
      mode_q      <= MODE_P;
      e_q         <= '0;
      d_q         <= '0;
      p_q         <= '0;
      i_q         <= '0;
      dterm_q     <= '0;
      i_acc_q     <= '0;
      e_last_q    <= '0;
      first_q     <= 1'b1;
      sat_hi_q    <= 1'b0;
      sat_lo_q    <= 1'b0;
      clr_pend_q  <= 1'b0;
      pwm_q       <= '0;
      sat_flag_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      sensor_q    <= sensor_d;
      target_q    <= target_d;
      kp_q        <= kp_d;
      ki_q        <= ki_d;
      kd_q        <= kd_d;
      mode_q      <= mode_d;
      e_q         <= e_d;
      d_q         <= d_d;
      p_q         <= p_d;
      i_q         <= i_d;
      dterm_q     <= dterm_d;
      i_acc_q     <= i_acc_d;
      e_last_q    <= e_last_d;
      first_q     <= first_d;
      sat_hi_q    <= sat_hi_d;
      sat_lo_q    <= sat_lo_d;
      clr_pend_q  <= clr_pend_d;
      pwm_q       <= pwm_d;
      sat_flag_q  <= sat_flag_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign sample_ready = (state_q == S_IDLE);
  assign pwm_out      = pwm_q;
  assign sat_flag     = sat_flag_q;
  assign out_valid    = out_valid_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_pid_position_ctrl.sv
// Bench for pid_position_ctrl: directed scenarios plus randomized samples,
// all checked against a behavioural PID model held in plain integers.
module tb_pid_position_ctrl;

  localparam int W       = 16;
  localparam int FRAC    = 8;
  localparam int OUT_MAX = 1000;
  localparam int OUT_MIN = -1000;
  localparam int I_MAX   = 25;
  localparam longint WHI = 32767;
  localparam longint WLO = -32768;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         sample_valid;
  logic         sample_ready;
  logic [W-1:0] sensor, target, kp, ki, kd;
  logic [1:0]   mode;
  logic         clear_i;
  logic [W-1:0] pwm_out;
  logic         out_valid;
  logic         sat_flag;
  logic [2:0]   state_o;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  longint m_iacc, m_elast;
  bit     m_first, m_hi, m_lo;

  logic [W:0] exp_q[$];

  pid_position_ctrl #(
    .W       (W),
    .FRAC    (FRAC),
    .OUT_MAX (OUT_MAX),
    .OUT_MIN (OUT_MIN),
    .I_MAX   (I_MAX)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .sensor       (sensor),
    .target       (target),
    .kp           (kp),
    .ki           (ki),
    .kd           (kd),
    .mode         (mode),
    .clear_i      (clear_i),
    .pwm_out      (pwm_out),
    .out_valid    (out_valid),
    .sat_flag     (sat_flag),
    .state_o      (state_o)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- model ----------------
  function automatic longint clampl(input longint v, input longint hi, input longint lo);
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  // Gain times value in Q.FRAC, rounded toward minus infinity, held in W bits.
  function automatic longint fx_mul(input longint g, input longint x);
    longint prod, q;
    prod = g * x;
    q = prod / (longint'(1) << FRAC);
    if ((prod % (longint'(1) << FRAC)) != 0 && prod < 0) q = q - 1;
    return clampl(q, WHI, WLO);
  endfunction

  task automatic model_reset();
    m_iacc = 0; m_elast = 0; m_first = 1; m_hi = 0; m_lo = 0;
  endtask

  task automatic model_clear();
    m_iacc = 0; m_elast = 0; m_first = 1; m_hi = 0; m_lo = 0;
  endtask

  task automatic model_sample(input longint s, input longint t, input longint gp,
                              input longint gi, input longint gd, input int md,
                              output longint pwm, output bit sat);
    longint e, d, p, i, dt, u, cand;
    e = clampl(t - s, WHI, WLO);
    d = m_first ? 0 : clampl(e - m_elast, WHI, WLO);
    p = fx_mul(gp, e);
    if (md == 2 || md == 3) begin
      cand = clampl(m_iacc + e, I_MAX, -I_MAX);
      if (!((m_hi && e > 0) || (m_lo && e < 0))) m_iacc = cand;
      i = fx_mul(gi, m_iacc);
    end else begin
      i = 0;
    end
    dt = (md == 1 || md == 3) ? fx_mul(gd, d) : 0;
    u = p + i + dt;
    m_hi = (u > OUT_MAX);
    m_lo = (u < OUT_MIN);
    pwm = clampl(u, OUT_MAX, OUT_MIN);
    sat = m_hi || m_lo;
    m_elast = e;
    m_first = 0;
  endtask

  // ---------------- drivers ----------------
  task automatic pulse_clear();
    @(negedge clk);
    clear_i = 1'b1;
    @(posedge clk);
    #1;
    clear_i = 1'b0;
    model_clear();
  endtask

  // One full transaction: offer, accept, wait for result, compare.
  task automatic do_sample(input int s, input int t, input int gp, input int gi,
                           input int gd, input int md, input bit clr_acc,
                           input bit mid_clr, input string tag);
    longint exp_pwm;
    bit     exp_sat;
    logic [W-1:0] exp_w;
    int cyc;
    @(negedge clk);
    sensor = W'(s); target = W'(t); kp = W'(gp); ki = W'(gi); kd = W'(gd);
    mode = 2'(md); clear_i = clr_acc; sample_valid = 1'b1;
    n_checks++;
    if (sample_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL %s ready_idle: got %b want 1", tag, sample_ready);
    end
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    clear_i = 1'b0;
    if (clr_acc) model_clear();
    model_sample(longint'($signed(sensor)), longint'($signed(target)), longint'($signed(kp)),
                 longint'($signed(ki)), longint'($signed(kd)), md, exp_pwm, exp_sat);
    if (mid_clr) model_clear();
    exp_w = W'(exp_pwm);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 20) begin
      clear_i = (mid_clr && cyc == 2);
      if (cyc < 6) begin
        n_checks++;
        if (sample_ready !== 1'b0) begin
          n_errors++;
          $display("FAIL %s ready_busy: cycle %0d got %b want 0", tag, cyc, sample_ready);
        end
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    clear_i = 1'b0;
    n_checks++;
    if (cyc != 6) begin
      n_errors++;
      $display("FAIL %s latency: got %0d want 6", tag, cyc);
    end
    n_checks++;
    if (pwm_out !== exp_w) begin
      n_errors++;
      $display("FAIL %s pwm_out: got %0d want %0d", tag, $signed(pwm_out), $signed(exp_w));
    end
    n_checks++;
    if (sat_flag !== exp_sat) begin
      n_errors++;
      $display("FAIL %s sat_flag: got %b want %b", tag, sat_flag, exp_sat);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL %s out_valid_pulse: got %b want 0", tag, out_valid);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1;
    n_checks++;
    if (pwm_out !== '0) begin n_errors++; $display("FAIL reset pwm_out: got %0d want 0", $signed(pwm_out)); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    n_checks++;
    if (sat_flag !== 1'b0) begin n_errors++; $display("FAIL reset sat_flag: got %b want 0", sat_flag); end
    n_checks++;
    if (sample_ready !== 1'b1) begin n_errors++; $display("FAIL reset sample_ready: got %b want 1", sample_ready); end
  endtask

  task automatic test_p_mode();
    do_sample(40, 100, 16'h0100, 0, 0, 0, 0, 0, "p_basic");
    do_sample(40, 100, 16'h2000, 0, 0, 0, 0, 0, "p_sat_hi");
    do_sample(100, 40, 16'h2000, 0, 0, 0, 0, 0, "p_sat_lo");
    // Error saturation at the W-bit rails (kp = 1/256).
    do_sample(-32768, 32767, 1, 0, 0, 0, 0, 0, "p_err_sat_hi");
    do_sample(32767, -32768, 1, 0, 0, 0, 0, 0, "p_err_sat_lo");
  endtask

  task automatic test_pd_mode();
    pulse_clear();
    do_sample(0, 10, 0, 0, 16'h0100, 1, 0, 0, "pd_first");
    do_sample(0, 25, 0, 0, 16'h0100, 1, 0, 0, "pd_delta");
    pulse_clear();
    do_sample(0, 25, 0, 0, 16'h0100, 1, 0, 0, "pd_after_clear");
  endtask

  task automatic test_pi_mode();
    pulse_clear();
    for (int k = 0; k < 4; k++) do_sample(0, 10, 0, 16'h0100, 0, 2, 0, 0, "pi_accum");
  endtask

  task automatic test_antiwindup();
    pulse_clear();
    do_sample(0, 20, 16'h4000, 16'h0100, 0, 2, 0, 0, "aw_hi_1");
    do_sample(0, 20, 16'h4000, 16'h0100, 0, 2, 0, 0, "aw_hi_hold");
    do_sample(0, -1, 0, 16'h0100, 0, 2, 0, 0, "aw_hi_reveal");
    do_sample(0, -20, 16'h4000, 16'h0100, 0, 2, 0, 0, "aw_lo_1");
    do_sample(0, -20, 16'h4000, 16'h0100, 0, 2, 0, 0, "aw_lo_hold");
    do_sample(0, 1, 0, 16'h0100, 0, 2, 0, 0, "aw_lo_reveal");
  endtask

  task automatic test_clear_pending();
    pulse_clear();
    do_sample(0, 10, 0, 16'h0100, 16'h0100, 3, 0, 0, "clr_prep");
    do_sample(0, 30, 0, 16'h0100, 16'h0100, 3, 0, 1, "clr_inflight");
    do_sample(0, 50, 0, 16'h0100, 16'h0100, 3, 0, 0, "clr_applied");
    do_sample(0, 7, 0, 16'h0100, 16'h0100, 3, 1, 0, "clr_at_accept");
  endtask

  task automatic test_back_to_back();
    int acc_cnt, out_cnt, last_acc;
    bit ready_now, exp_ready;
    longint exp_pwm;
    bit exp_sat;
    logic [W:0] got, want;
    acc_cnt = 0; out_cnt = 0; last_acc = -100;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      if (acc_cnt < 8) begin
        sensor = W'(int'($urandom_range(0, 600)) - 300);
        target = W'(int'($urandom_range(0, 600)) - 300);
        kp = W'($urandom_range(0, 1024));
        ki = W'($urandom_range(0, 1024));
        kd = W'($urandom_range(0, 1024));
        mode = 2'($urandom_range(0, 3));
        sample_valid = 1'b1;
      end else begin
        sample_valid = 1'b0;
      end
      ready_now = sample_ready;
      exp_ready = (c - last_acc >= 7);
      n_checks++;
      if (ready_now !== exp_ready) begin
        n_errors++;
        $display("FAIL b2b ready: cycle %0d got %b want %b", c, ready_now, exp_ready);
      end
      @(posedge clk);
      if (ready_now && sample_valid) begin
        model_sample(longint'($signed(sensor)), longint'($signed(target)), longint'($signed(kp)),
                     longint'($signed(ki)), longint'($signed(kd)), int'(mode), exp_pwm, exp_sat);
        exp_q.push_back({exp_sat, W'(exp_pwm)});
        last_acc = c;
        acc_cnt++;
      end
      #1;
      if (out_valid === 1'b1) begin
        out_cnt++;
        got = {sat_flag, pwm_out};
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL b2b extra_out: got {sat,pwm}=%h want no output", got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            n_errors++;
            $display("FAIL b2b result: got {sat,pwm}=%h want %h", got, want);
          end
        end
      end
    end
    sample_valid = 1'b0;
    n_checks++;
    if (out_cnt != 8 || exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL b2b count: got %0d outputs (%0d pending) want 8 (0)", out_cnt, exp_q.size());
    end
  endtask

  task automatic test_reset_midop();
    int pulses;
    pulse_clear();
    do_sample(0, 5, 0, 16'h0100, 16'h0100, 3, 0, 0, "rst_prep1");
    do_sample(0, 8, 0, 16'h0100, 16'h0100, 3, 0, 0, "rst_prep2");
    @(negedge clk);
    sensor = '0; target = W'(30); mode = 2'd3; sample_valid = 1'b1;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    model_reset();
    n_checks++;
    if (pwm_out !== '0) begin n_errors++; $display("FAIL rst_mid pwm_out: got %0d want 0", $signed(pwm_out)); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_errors++; $display("FAIL rst_mid out_valid: got %b want 0", out_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 0) begin n_errors++; $display("FAIL rst_mid no_out: got %0d pulses want 0", pulses); end
    do_sample(0, 4, 0, 16'h0100, 16'h0100, 3, 0, 0, "rst_next_first");
  endtask

  task automatic test_random();
    int s, t, gp, gi, gd, md;
    bit ca, cm;
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        s = int'($urandom_range(0, 65535)) - 32768;
        t = int'($urandom_range(0, 65535)) - 32768;
      end else begin
        s = int'($urandom_range(0, 4000)) - 2000;
        t = int'($urandom_range(0, 4000)) - 2000;
      end
      gp = int'($urandom_range(0, 2048)) - 512;
      gi = int'($urandom_range(0, 2048)) - 512;
      gd = int'($urandom_range(0, 2048)) - 512;
      md = int'($urandom_range(0, 3));
      ca = ($urandom_range(0, 9) == 0);
      cm = ($urandom_range(0, 9) == 0);
      do_sample(s, t, gp, gi, gd, md, ca, cm, "random");
    end
  endtask

  // ---------------- sequence ----------------
  initial begin
    sample_valid = 1'b0;
    clear_i = 1'b0;
    sensor = '0; target = '0; kp = '0; ki = '0; kd = '0; mode = '0;
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_p_mode();
    test_pd_mode();
    test_pi_mode();
    test_antiwindup();
    test_clear_pending();
    test_back_to_back();
    test_reset_midop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pid_position_ctrl.md
Name: pid_position_ctrl

Overview:
- Parametrised successor to the team's position PD loop.
- Implements a fixed-point PID with a selectable mode (P / PD / PI / PID), signed error arithmetic, and a clamped integrator with conditional-integration anti-windup.
- Output saturates to a configurable range.
- One shared multiplier is time-multiplexed by an FSM.
- A valid/ready sample handshake feeds it. The PWM stage consumes pwm_out when out_valid is high.

Parameters:
- W, 16: width of sensor, target, gains, pwm_out (signed two's complement)
- FRAC, 8: fractional bits of kp/ki/kd (0x0100 = 1.0)
- OUT_MAX, 1000: upper output clamp (signed)
- OUT_MIN, -1000: lower output clamp (signed)
- I_MAX, 4096: integrator magnitude clamp (accumulator held in [-I_MAX, I_MAX])

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- sample_valid  in  1  new sensor/target pair offered
- sample_ready  out  1  block can accept a sample (high only in IDLE)
- sensor  in  W  measured position, signed
- target  in  W  commanded position, signed
- kp, ki, kd  in  W each  gains, signed Q(W-FRAC).FRAC
- mode  in  2  0=P, 1=PD, 2=PI, 3=PID; sampled at accept
- clear_i  in  1  clear integrator and derivative history
- pwm_out  out  W  saturated control output, signed
- out_valid  out  1  one-cycle pulse: pwm_out updated
- sat_flag  out  1  last output was clamped

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - pwm_out=0, out_valid=0, sat_flag=0, sample_ready=1 once released.
  - Integrator=0, e_last=0, first=1.
- Accept: in IDLE, when sample_valid && sample_ready, latch sensor, target, gains and mode on that edge. The FSM then enters ERR.
- Inputs offered while not in IDLE are ignored; sample_ready=0 in that time.
- FSM sequence: IDLE -> ERR -> MUL_P -> MUL_I -> MUL_D -> SUM -> DONE -> IDLE. One state per cycle with no stalls.
- ERR:
  - e = target - sensor, computed in W+1 bits and saturated to W.
  - If first=1, d = 0; otherwise d = e - e_last, saturated to W.
- MUL_P: p = (kp*e) >>> FRAC (2W-bit signed product, arithmetic shift).
- MUL_I (modes PI/PID only):
  - Candidate = i_acc + e, clamped to [-I_MAX, I_MAX].
  - Anti-windup: skip the update when the previous output saturated high and e>0, or saturated low and e<0.
  - Then i = (ki*i_acc_new) >>> FRAC.
  - In modes P/PD: i=0 and the integrator holds.
- MUL_D: dterm = (kd*d) >>> FRAC in modes PD/PID; else 0.
- SUM:
  - u = p + i + dterm in W+3 bits, clamped to [OUT_MIN, OUT_MAX].
  - Register pwm_out and sat_flag (1 if clamped), plus saturation direction.
  - e_last <= e, first <= 0.
- DONE: out_valid=1 for exactly one cycle.
- Latency: out_valid goes high 6 cycles after the accept edge. Maximum throughput is one sample per 7 cycles.
- clear_i:
  - In IDLE: clears the integrator, sets first=1, and clears the saturation direction on the next edge.
  - In any other state: the clear is latched as pending and applied on DONE->IDLE. The in-flight result is unaffected.
  - clear_i at the same edge as an accept: the clear applies first and the sample uses a zero integrator with d=0.
- Wrap-around: no intermediate may wrap; every narrowing point saturates.
- rst_n deasserted mid-operation aborts the computation: no out_valid, all state zeroed.

Decomposition:
- Shared package pid_pkg:
  - mode enum (MODE_P, MODE_PD, MODE_PI, MODE_PID)
  - FSM state enum
  - function sat_signed(value, hi, lo)
- One sub-module, pid_mul_shift: the shared signed W×W multiply with arithmetic >>> FRAC. Operands are muxed by state.

Test Plan (W=16, FRAC=8, default clamps):
1. P mode, kp=0x0100, target=100, sensor=40 -> out_valid 6 cycles after accept, pwm_out=60, sat_flag=0.
2. P mode, kp=0x2000 (32.0), e=60 -> pwm_out=1000, sat_flag=1. Same with target=40, sensor=100 -> pwm_out=-1000.
3. PD mode, kp=0, kd=0x0100, e=10 then e=25 -> pwm_out 0 then 15. Assert clear_i, then e=25 -> 0 (first sample).
4. PI mode, kp=0, ki=0x0100, I_MAX=25, e=10 x4 -> pwm_out 10, 20, 25, 25. With ki=0x1000 and OUT_MAX hit, the integrator holds while e>0.
5. Handshake: sample_valid held high continuously -> sample_ready pulses only in IDLE; exactly one accept per 7 cycles; no lost or duplicated out_valid.
6. Reset: drive rst_n=0 during MUL_I -> pwm_out=0, out_valid never pulses. The next sample behaves as first (d=0, integrator=0).
